// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_mp_sb : multi-port register file with per-register busy scoreboard
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_WR-1:0]                        wr_en_i,
  input  logic [NUM_WR*($clog2(NUM_REGS)+1)-1:0]   wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]                 wr_data_i,
  input  logic [NUM_RD*($clog2(NUM_REGS)+1)-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]                 rd_data_o,
  output logic [NUM_RD-1:0]                        rd_busy_o,
  input  logic                                     iss_en_i,
  input  logic [$clog2(NUM_REGS):0]                iss_addr_i,
  input  logic                                     flush_i
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int AW = IW + 1;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic [NUM_WR-1:0]   w_wr_vld;
  logic [IW-1:0]       w_wr_idx [NUM_WR];
  logic [NUM_REGS-1:0] w_hit;
  logic [DATA_W-1:0]   w_wdat [NUM_REGS];
  logic [IW-1:0]       w_iss_idx;
  logic                w_iss_vld;

  // The top address bit marks a non-register operand; such writes and issues vanish.
  generate
    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
      assign w_wr_idx[p] = wr_addr_i[p*AW +: IW];
      assign w_wr_vld[p] = wr_en_i[p] && !wr_addr_i[p*AW+IW] &&
                           !((ZERO_REG != 0) && (w_wr_idx[p] == '0));
    end
  endgenerate

  assign w_iss_idx = iss_addr_i[IW-1:0];
  assign w_iss_vld = iss_en_i && !iss_addr_i[IW] &&
                     !((ZERO_REG != 0) && (w_iss_idx == '0));

  // Ports scanned in ascending order so the highest-indexed writer wins a conflict.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_hit[i]  = 1'b0;
      w_wdat[i] = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (w_wr_vld[p] && (w_wr_idx[p] == IW'(i))) begin
          w_hit[i]  = 1'b1;
          w_wdat[i] = wr_data_i[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Issue is applied after retire-clear so a new producer keeps the bit set.
  always_comb begin
    busy_d = busy_q & ~w_hit;
    if (w_iss_vld) busy_d[w_iss_idx] = 1'b1;
    if (flush_i)   busy_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_hit[i]) regs_q[i] <= w_wdat[i];
      end
      busy_q <= busy_d;
    end
  end

  generate
    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [IW-1:0] w_idx;
      logic          w_none;
      logic          w_fwd;

      assign w_idx  = rd_addr_i[r*AW +: IW];
      assign w_none = rd_addr_i[r*AW+IW] || ((ZERO_REG != 0) && (w_idx == '0));
      assign w_fwd  = (BYPASS != 0) && w_hit[w_idx];

      assign rd_data_o[r*DATA_W +: DATA_W] = w_none ? '0 :
                                             (w_fwd ? w_wdat[w_idx] : regs_q[w_idx]);
      assign rd_busy_o[r] = !w_none && busy_q[w_idx] && !w_fwd;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_mp_sb : bench for regfile_mp_sb, bypassing and non-bypassing builds
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [11:0] wr_addr;
  logic [63:0] wr_data;
  logic [11:0] rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        iss_en;
  logic [5:0]  iss_addr;
  logic        flush;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  regfile_mp_sb #(.BYPASS(1)) u_dut_a (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush)
  );

  regfile_mp_sb #(.BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit is_reg(input logic [5:0] a);
    return !a[5] && (a[4:0] != 5'd0);
  endfunction

  function automatic bit wvalid(input int p);
    return wr_en[p] && is_reg(wr_addr[p*6 +: 6]);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [5:0] a, input bit byp);
    logic [31:0] v;
    if (!is_reg(a)) return 32'd0;
    v = m_regs[a[4:0]];
    if (byp)
      for (int p = 0; p < 2; p++)
        if (wvalid(p) && wr_addr[p*6 +: 5] == a[4:0]) v = wr_data[p*32 +: 32];
    return v;
  endfunction

  function automatic logic exp_busy(input logic [5:0] a, input bit byp);
    if (!is_reg(a)) return 1'b0;
    if (byp)
      for (int p = 0; p < 2; p++)
        if (wvalid(p) && wr_addr[p*6 +: 5] == a[4:0]) return 1'b0;
    return m_busy[a[4:0]];
  endfunction

  function automatic logic [31:0] next_busy();
    logic [31:0] nb;
    nb = m_busy;
    for (int p = 0; p < 2; p++)
      if (wvalid(p)) nb[wr_addr[p*6 +: 5]] = 1'b0;
    if (iss_en && is_reg(iss_addr)) nb[iss_addr[4:0]] = 1'b1;
    if (flush) nb = 32'd0;
    return nb;
  endfunction

  // Reference state: later port assignments override earlier ones.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_busy <= 32'd0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wvalid(p)) m_regs[wr_addr[p*6 +: 5]] <= wr_data[p*32 +: 32];
      m_busy <= next_busy();
    end
  end

  always @(negedge clk) begin
    for (int r = 0; r < 2; r++) begin
      check($sformatf("rd_a%0d", r), rd_data_a[r*32 +: 32], exp_rd(rd_addr[r*6 +: 6], 1'b1));
      check($sformatf("rd_b%0d", r), rd_data_b[r*32 +: 32], exp_rd(rd_addr[r*6 +: 6], 1'b0));
      check($sformatf("busy_a%0d", r), 32'(rd_busy_a[r]), 32'(exp_busy(rd_addr[r*6 +: 6], 1'b1)));
      check($sformatf("busy_b%0d", r), 32'(rd_busy_b[r]), 32'(exp_busy(rd_addr[r*6 +: 6], 1'b0)));
    end
  end

  task automatic idle();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [5:0] rand_addr();
    logic [4:0] lo;
    lo = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    return {($urandom_range(0, 7) == 0), lo};
  endfunction

  initial begin
    rst = 1'b1; idle(); rd_addr = {6'd2, 6'd1};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("reset_rd", rd_data_a[31:0], 32'd0);
    check("reset_busy", 32'(rd_busy_a), 32'd0);

    for (int i = 1; i < 32; i += 2) begin
      step();
      wr_en   = (i == 31) ? 2'b01 : 2'b11;
      wr_addr = {6'(i + 1), 6'(i)};
      wr_data = {32'(i + 1), 32'(i)};
    end
    step(); idle(); iss_en = 1'b1; iss_addr = 6'd4; rd_addr = {6'd31, 6'd5};
    #1 check("fill_x5", rd_data_a[31:0], 32'd5);
    check("fill_x31", rd_data_a[63:32], 32'd31);
    step(); idle(); rd_addr = {6'd4, 6'd5};
    #1 check("pre_rst_busy_x4", 32'(rd_busy_a[1]), 32'd1);
    #1 rst = 1'b1;
    #1 check("async_rst_x5", rd_data_a[31:0], 32'd0);
    check("async_rst_busy", 32'(rd_busy_a), 32'd0);
    rst = 1'b0;

    step(); wr_en = 2'b01; wr_addr = {6'd0, 6'd5}; wr_data = {32'd0, 32'h55};
    step(); wr_en = 2'b11; wr_addr = {6'h25, 6'h00}; wr_data = {32'hDEAD, 32'hDEAD};
    rd_addr = {6'h25, 6'h00};
    #1 check("zero_x0_same", rd_data_a[31:0], 32'd0);
    check("noreg_same", rd_data_a[63:32], 32'd0);
    step(); idle(); rd_addr = {6'd5, 6'd0};
    #1 check("zero_x0", rd_data_a[31:0], 32'd0);
    check("x5_unchanged", rd_data_a[63:32], 32'h55);

    step(); wr_en = 2'b01; wr_addr = {6'd0, 6'd3}; wr_data = {32'd0, 32'h1234};
    rd_addr = {6'd0, 6'd3};
    #1 check("bypass_on", rd_data_a[31:0], 32'h1234);
    check("bypass_off_old", rd_data_b[31:0], 32'd0);
    step(); idle();
    #1 check("bypass_off_next", rd_data_b[31:0], 32'h1234);

    step(); wr_en = 2'b11; wr_addr = {6'd7, 6'd7}; wr_data = {32'h5555, 32'hAAAA};
    rd_addr = {6'd0, 6'd7};
    #1 check("conflict_bypass", rd_data_a[31:0], 32'h5555);
    step(); idle();
    #1 check("conflict_a", rd_data_a[31:0], 32'h5555);
    check("conflict_b", rd_data_b[31:0], 32'h5555);

    step(); iss_en = 1'b1; iss_addr = 6'd9; rd_addr = {6'd0, 6'd9};
    #1 check("iss_not_yet", 32'(rd_busy_a[0]), 32'd0);
    step(); idle();
    #1 check("iss_busy_a", 32'(rd_busy_a[0]), 32'd1);
    check("iss_busy_b", 32'(rd_busy_b[0]), 32'd1);
    step(); wr_en = 2'b01; wr_addr = {6'd0, 6'd9}; wr_data = {32'd0, 32'h99};
    iss_en = 1'b1; iss_addr = 6'd9;
    #1 check("wr_hides_busy_a", 32'(rd_busy_a[0]), 32'd0);
    check("wr_busy_b", 32'(rd_busy_b[0]), 32'd1);
    step(); idle();
    #1 check("set_wins", 32'(rd_busy_a[0]), 32'd1);
    check("set_wins_data", rd_data_a[31:0], 32'h99);
    step(); flush = 1'b1;
    step(); idle();
    #1 check("flush_clears", 32'(rd_busy_a[0]), 32'd0);
    step(); flush = 1'b1; iss_en = 1'b1; iss_addr = 6'd10; rd_addr = {6'd0, 6'd10};
    step(); idle();
    #1 check("flush_over_iss", 32'(rd_busy_a[0]), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      step();
      wr_en    = 2'($urandom_range(0, 3));
      wr_addr  = {rand_addr(), rand_addr()};
      wr_data  = {$urandom, $urandom};
      rd_addr  = {rand_addr(), rand_addr()};
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = rand_addr();
      flush    = ($urandom_range(0, 15) == 0);
    end

    step(); idle();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
